// File: rtl/spu_register_file.sv
// Unified 128x128 SPU register file: 6 registered read ports, even/odd writeback ports; SPU_RF_BYPASS_EN enables write-through reads.
// Latency: 1 cycle read, writes commit at the edge; backpressure: none, every cycle reads and outputs update.
module spu_register_file #(
  parameter int NUM_REGS = 128,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra_addr_even,
  input  logic [ADDR_W-1:0] rb_addr_even,
  input  logic [ADDR_W-1:0] rc_addr_even,
  input  logic [ADDR_W-1:0] ra_addr_odd,
  input  logic [ADDR_W-1:0] rb_addr_odd,
  input  logic [ADDR_W-1:0] rc_addr_odd,
  output logic [0:DATA_W-1] ra_even,
  output logic [0:DATA_W-1] rb_even,
  output logic [0:DATA_W-1] rc_even,
  output logic [0:DATA_W-1] ra_odd,
  output logic [0:DATA_W-1] rb_odd,
  output logic [0:DATA_W-1] rc_odd,
  input  logic [0:DATA_W-1] rt_even_wb,
  input  logic [ADDR_W-1:0] rt_addr_even_wb,
  input  logic              reg_write_even_wb,
  input  logic [0:DATA_W-1] rt_odd_wb,
  input  logic [ADDR_W-1:0] rt_addr_odd_wb,
  input  logic              reg_write_odd_wb,
  output logic              wr_conflict
);

  logic [0:DATA_W-1] mem [NUM_REGS];

  logic even_ok;
  logic odd_ok;
  assign even_ok = reg_write_even_wb && (int'(rt_addr_even_wb) < NUM_REGS);
  assign odd_ok  = reg_write_odd_wb  && (int'(rt_addr_odd_wb)  < NUM_REGS);

  function automatic logic [0:DATA_W-1] rd(input logic [ADDR_W-1:0] a);
    logic [0:DATA_W-1] v;
    v = '0;
    if (int'(a) < NUM_REGS) begin
      v = mem[a];
`ifdef SPU_RF_BYPASS_EN
      // Odd checked last so it matches the value the array will hold.
      if (even_ok && rt_addr_even_wb == a) v = rt_even_wb;
      if (odd_ok  && rt_addr_odd_wb  == a) v = rt_odd_wb;
`endif
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      ra_even     <= '0;
      rb_even     <= '0;
      rc_even     <= '0;
      ra_odd      <= '0;
      rb_odd      <= '0;
      rc_odd      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      ra_even <= rd(ra_addr_even);
      rb_even <= rd(rb_addr_even);
      rc_even <= rd(rc_addr_even);
      ra_odd  <= rd(ra_addr_odd);
      rb_odd  <= rd(rb_addr_odd);
      rc_odd  <= rd(rc_addr_odd);
      // Odd holds the later instruction of the pair, so its write lands last.
      if (even_ok) mem[rt_addr_even_wb] <= rt_even_wb;
      if (odd_ok)  mem[rt_addr_odd_wb]  <= rt_odd_wb;
      wr_conflict <= reg_write_even_wb && reg_write_odd_wb &&
                     (rt_addr_even_wb == rt_addr_odd_wb);
    end
  end

endmodule
